exec_stage: RTL and testbench
=============================

# exec_stage

Registered execute stage wrapped around the combinational 16-bit `alu`. It accepts one operation (opcode plus two operands) through a valid/ready handshake and latches the operands. It drives the ALU from those registers and presents a registered result with status flags through a second valid/ready handshake. It sits between the decode/operand-fetch logic (upstream) and register write-back (downstream).

## Interface
- `DATA_WIDTH`, default 16: operand and result width.
- `HIGH`, default `DATA_WIDTH-1`: MSB index.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `in_valid` input, 1 bit: upstream has an operation on `oc`/`a`/`b`.
- `in_ready` output, 1 bit: stage can accept an operation this cycle.
- `oc` input, 3 bits: opcode. ADD=0, SUB=1, MUL=2, DIV=3, NOT=4, XOR=5, OR=6, AND=7.
- `a` input, DATA_WIDTH: operand A.
- `b` input, DATA_WIDTH: operand B. Ignored for NOT.
- `out_valid` output, 1 bit: `f` and the flags hold a valid result.
- `out_ready` input, 1 bit: downstream consumes the result this cycle.
- `f` output, DATA_WIDTH: registered result.
- `z` output, 1 bit: result equals zero.
- `n` output, 1 bit: `f[HIGH]`.
- `err` output, 1 bit: DIV with `b==0`.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid`, latch `oc`/`a`/`b` into the operand registers and go to EXEC.
- EXEC:
  - `in_ready=0`. The ALU is driven only from the operand registers.
  - At the end of the cycle, register the ALU output into `f`, compute `z`/`n`/`err`, and go to DONE.
- DONE:
  - `out_valid=1`. `f`, `z`, `n` and `err` stay stable until the transfer.
  - If `out_ready=0`, stay in DONE.
  - If `out_ready=1` and `in_valid=0`, go to IDLE.
  - If `out_ready=1` and `in_valid=1`, latch the new operation and go straight to EXEC (back-to-back).
- `in_ready` equals `(state==IDLE) | (state==DONE & out_ready)`. This is a combinational path from `out_ready`, which is intentional and documented.
- Arithmetic:
  - All results are truncated modulo 2^DATA_WIDTH.
  - SUB wraps; for example 0-1 gives 0xFFFF.
  - MUL keeps the low DATA_WIDTH bits.
  - DIV is an unsigned quotient.
- Divide by zero:
  - The stage itself forces `f=0` and `err=1`; the ALU DIV output is not used in this case.
  - `z=1` and `n=0`.
- `err=0` for every opcode other than DIV.
- The flags always describe the value registered in `f`.

## Timing
- Reset values while `rst_n=0` at a rising edge:
  - state = IDLE.
  - `out_valid=0`, `f=0`, `z=0`, `n=0`, `err=0`.
  - Operand registers = 0.
  - `in_ready=1` from the first cycle after reset.
- Latency: an operation accepted at edge k has `out_valid=1` after edge k+1.
- Throughput:
  - With `out_ready` held high and `in_valid` held high, one result every 2 cycles.
  - The minimum IDLE-path period is 3 cycles.
- Handshake rules:
  - A transfer happens only on an edge where valid and ready are both 1.
  - `out_valid` never drops without a transfer.
  - Inputs are ignored whenever `in_ready=0`. Upstream must hold them, but the stage does not depend on that.
- Reset mid-operation (in EXEC or DONE): the pending operation and result are discarded, and all outputs return to their reset values on that edge.
- Opcode or operand changes while in EXEC or DONE have no effect on `f`.

## Structure
- Shared package `exec_pkg`:
  - Opcode localparams `OC_ADD`…`OC_AND` (3 bits).
  - State encoding `ST_IDLE=2'd0`, `ST_EXEC=2'd1`, `ST_DONE=2'd2`.
  - Encoding 2'd3 is illegal and recovers to IDLE.
- One sub-module: `alu`, instantiated with `DATA_WIDTH` passed through and fed from the operand registers.
- All other logic is in `exec_stage`: FSM, operand registers, result/flag registers, and the DIV-by-zero override.

## Test plan
- Reset, then ADD 0x0003+0x0004 with `out_ready=1`:
  - `in_ready` drops after acceptance.
  - After 1 cycle: `out_valid=1`, `f=0x0007`, `z=0`, `n=0`, `err=0`.
- SUB 0x0000-0x0001, then MUL 0x0100*0x0100:
  - SUB gives `f=0xFFFF`, `n=1`.
  - MUL gives `f=0x0000`, `z=1`.
- DIV 0x0064/0x0000: `f=0`, `err=1`, `z=1`.
- DIV 0x0064/0x0007: `f=0x000E`, `err=0`.
- Backpressure, with `out_ready=0` for 5 cycles after XOR 0xF0F0^0x0FF0:
  - `out_valid` stays 1 and `f` stays 0xFF00.
  - `in_ready=0` throughout.
  - A changing `a` is ignored.
- Back-to-back: with `in_valid` and `out_ready` held high for 4 ops (ADD, OR, AND, NOT of 0x00FF):
  - Results appear every 2 cycles, in order and correct.
  - NOT gives `f=0xFF00`.
- Assert `rst_n=0` during EXEC of ADD 1+1:
  - Next cycle: `out_valid=0`, `f=0`, `in_ready=1`.
  - No stale result ever appears.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcode values and FSM state encoding.
package exec_pkg;

  // Opcode encoding as presented by decode.
  localparam logic [2:0] OC_ADD = 3'd0;
  localparam logic [2:0] OC_SUB = 3'd1;
  localparam logic [2:0] OC_MUL = 3'd2;
  localparam logic [2:0] OC_DIV = 3'd3;
  localparam logic [2:0] OC_NOT = 3'd4;
  localparam logic [2:0] OC_XOR = 3'd5;
  localparam logic [2:0] OC_OR  = 3'd6;
  localparam logic [2:0] OC_AND = 3'd7;

  // Stage FSM states; encoding 2'd3 is unused and falls back to idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True when the operation is an unsigned divide by zero, which the stage
  // resolves itself instead of trusting the ALU quotient.
  function automatic logic is_div_by_zero(input logic [2:0] op, input logic b_is_zero);
    return (op == OC_DIV) && b_is_zero;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: eight operations, all results truncated to DATA_WIDTH bits.
module alu
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [2:0]            oc,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] f
);

  // Operation select; divide by zero yields 0 here to keep the output defined.
  always_comb begin
    f = '0;
    case (oc)
      OC_ADD: f = a + b;
      OC_SUB: f = a - b;
      OC_MUL: f = a * b;
      OC_DIV: f = (b == '0) ? '0 : (a / b);
      OC_NOT: f = ~a;
      OC_XOR: f = a ^ b;
      OC_OR:  f = a | b;
      OC_AND: f = a & b;
      default: f = '0;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// Registered execute stage: latches one operation through a valid/ready
// handshake, runs it through the ALU for one cycle and holds the result and
// flags until downstream takes them.
module exec_stage
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int HIGH       = DATA_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            oc,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] f,
  output logic                  z,
  output logic                  n,
  output logic                  err
);

  state_t                  state_reg;
  state_t                  state_next;

  logic [2:0]              oc_reg;
  logic [DATA_WIDTH-1:0]   a_reg;
  logic [DATA_WIDTH-1:0]   b_reg;

  logic [DATA_WIDTH-1:0]   f_reg;
  logic                    z_reg;
  logic                    n_reg;
  logic                    err_reg;

  logic                    accept;
  logic                    div_zero;
  logic [DATA_WIDTH-1:0]   alu_f;
  logic [DATA_WIDTH-1:0]   f_next;

  // The ALU only ever sees the latched operands, never the live inputs.
  alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .oc(oc_reg),
    .a (a_reg),
    .b (b_reg),
    .f (alu_f)
  );

  // in_ready depends combinationally on out_ready in DONE so a result can be
  // retired and the next operation accepted on the same edge.
  assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
  assign out_valid = (state_reg == ST_DONE);
  assign accept    = in_valid && in_ready;

  // Divide by zero is forced to a zero result with err set.
  assign div_zero  = is_div_by_zero(oc_reg, (b_reg == '0));
  assign f_next    = div_zero ? '0 : alu_f;

  assign f   = f_reg;
  assign z   = z_reg;
  assign n   = n_reg;
  assign err = err_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; the unused encoding recovers to idle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = in_valid ? ST_EXEC : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Operand registers load only on an accepted handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oc_reg <= OC_ADD;
      a_reg  <= '0;
      b_reg  <= '0;
    end else if (accept) begin
      oc_reg <= oc;
      a_reg  <= a;
      b_reg  <= b;
    end
  end

  // Result and flags are captured at the end of EXEC and held through DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_reg   <= '0;
      z_reg   <= 1'b0;
      n_reg   <= 1'b0;
      err_reg <= 1'b0;
    end else if (state_reg == ST_EXEC) begin
      f_reg   <= f_next;
      z_reg   <= (f_next == '0);
      n_reg   <= f_next[HIGH];
      err_reg <= div_zero;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: table of vectors plus hand-written
// handshake sequences; expected results flow through a scoreboard queue.
module tb_exec_stage;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  oc;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] f;
  logic        z;
  logic        n;
  logic        err;

  typedef struct {
    logic [2:0]  oc;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] f;
    logic        z;
    logic        n;
    logic        err;
  } vec_t;

  typedef struct {
    logic [15:0] f;
    logic        z;
    logic        n;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   out_cyc[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  exec_stage #(.DATA_WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .oc       (oc),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .f        (f),
    .z        (z),
    .n        (n),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Cycle counter used to measure result spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: retire results against the scoreboard, then record acceptances.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_result: got f=0x%h, expected no result", f);
      end else begin
        e = sb.pop_front();
        check("result_f", f, e.f);
        check("result_z", z, e.z);
        check("result_n", n, e.n);
        check("result_err", err, e.err);
        $display("xfer cycle %0d: f=0x%h z=%0b n=%0b err=%0b (expected f=0x%h z=%0b n=%0b err=%0b)",
                 cyc, f, z, n, err, e.f, e.z, e.n, e.err);
        out_cyc.push_back(cyc);
      end
    end
    if (rst_n === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1) begin
      sb.push_back(cur_exp);
    end
  end

  task automatic drive(input logic [2:0] op, input logic [15:0] va, input logic [15:0] vb,
                       input logic [15:0] ef, input logic ez, input logic en, input logic eerr);
    oc = op;
    a  = va;
    b  = vb;
    cur_exp.f   = ef;
    cur_exp.z   = ez;
    cur_exp.n   = en;
    cur_exp.err = eerr;
  endtask

  // Hold in_valid until in_ready is seen at a negedge; leaves in_valid set.
  task automatic wait_accept(input string name);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL %s_accept_timeout: got in_ready=%0b, expected 1 within 50 cycles", name, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", sb.size(), 0);
  endtask

  vec_t vecs[12];
  vec_t b2b[4];

  initial begin
    vecs[0]  = '{OC_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{OC_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{OC_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{OC_DIV, 16'h0064, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{OC_DIV, 16'h0064, 16'h0007, 16'h000E, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OC_XOR, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{OC_OR,  16'h8000, 16'h0001, 16'h8001, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{OC_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OC_NOT, 16'h0000, 16'hABCD, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{OC_MUL, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{OC_SUB, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{OC_DIV, 16'hFFFF, 16'h0010, 16'h0FFF, 1'b0, 1'b0, 1'b0};

    b2b[0] = '{OC_ADD, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0};
    b2b[1] = '{OC_OR,  16'h00FF, 16'h0F00, 16'h0FFF, 1'b0, 1'b0, 1'b0};
    b2b[2] = '{OC_AND, 16'h00FF, 16'h0F0F, 16'h000F, 1'b0, 1'b0, 1'b0};
    b2b[3] = '{OC_NOT, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b1, 1'b0};

    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(OC_ADD, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_f", f, 0);
    check("rst_z", z, 0);
    check("rst_n_flag", n, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);

    // First ADD with latency check.
    @(posedge clk);
    #1;
    drive(OC_ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    check("add_in_ready_before", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("add_in_ready_exec", in_ready, 0);
    check("add_out_valid_exec", out_valid, 0);
    @(negedge clk);
    check("add_out_valid_done", out_valid, 1);
    drain();

    // Table-driven vectors.
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].oc, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].z, vecs[i].n, vecs[i].err);
      wait_accept("vec");
      in_valid = 1'b0;
    end
    drain();

    // Backpressure: result held, input side blocked, changing a ignored.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    drive(OC_XOR, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b1, 1'b0);
    wait_accept("bp");
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      oc = OC_ADD;
      a  = 16'($urandom);
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_f", f, 16'hFF00);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Back-to-back with in_valid and out_ready held high.
    out_cyc.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      drive(b2b[i].oc, b2b[i].a, b2b[i].b, b2b[i].f, b2b[i].z, b2b[i].n, b2b[i].err);
      wait_accept("b2b");
    end
    in_valid = 1'b0;
    drain();
    check("b2b_count", out_cyc.size(), 4);
    if (out_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
        check("b2b_spacing", out_cyc[i] - out_cyc[i-1], 2);
      end
    end

    // Reset during EXEC discards the pending ADD 1+1.
    @(posedge clk);
    #1;
    drive(OC_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    wait_accept("rst");
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_f", f, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_result", out_valid, 0);
    end

    check("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
